// File: rtl/c499_sec_encoder.sv
// c499_sec_encoder
// Streaming check-bit generator for the c499 32-bit single-error corrector.
// Two-stage valid/ready pipeline: S1 captures the word (and any pending
// injection), S2 computes the eight check bits from clean data, applies the
// optional one-shot flip and drives the registered outputs.
//
// Handshake contract: a transfer happens on a rising clk edge where valid and
// ready are both 1. A producer holds valid and its payload steady until the
// transfer. Ready may depend combinationally on the downstream ready.
// o/p payload (out_data, out_check, out_valid) is held while out_valid is 1
// and out_ready is 0.
module c499_sec_encoder #(
    parameter int CNT_W  = 16,
    parameter int INJ_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             inj_req,
    input  logic [5:0]       inj_pos,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [7:0]       out_check,
    output logic             out_en,
    output logic [CNT_W-1:0] word_cnt,
    output logic             inj_done
);

    // Stage 1: captured word plus the flip request that travels with it.
    logic             r_s1_valid;
    logic [31:0]      r_s1_data;
    logic             r_s1_inj;
    logic [5:0]       r_s1_pos;

    // Stage 2: output registers.
    logic             r_s2_valid;
    logic [31:0]      r_s2_data;
    logic [7:0]       r_s2_check;
    logic             r_s2_inj;

    // Injection arming state.
    logic             r_inj_armed;
    logic [5:0]       r_inj_pos;

    // Completed output handshakes.
    logic [CNT_W-1:0] r_word_cnt;

    logic             w_in_fire;
    logic             w_s1_adv;
    logic             w_out_fire;
    logic             w_inj_take;
    logic [5:0]       w_inj_sel_pos;
    logic [7:0]       w_clean_check;
    logic [31:0]      w_flip_data;
    logic [7:0]       w_flip_check;

    // Handshake and stage-advance qualifiers.
    always_comb begin
        in_ready   = !r_s1_valid || (!r_s2_valid || out_ready);
        w_in_fire  = in_valid && in_ready;
        w_s1_adv   = r_s1_valid && (!r_s2_valid || out_ready);
        w_out_fire = r_s2_valid && out_ready;
    end

    // An injection is bound to the first accepted word at or after arming;
    // a request in the same cycle as the handshake wins with its own position.
    always_comb begin
        w_inj_take    = (INJ_EN != 0) && w_in_fire && (r_inj_armed || inj_req);
        w_inj_sel_pos = inj_req ? inj_pos : r_inj_pos;
    end

    // Check bits from the clean S1 word; each is the parity of twelve data bits.
    always_comb begin
        w_clean_check    = '0;
        w_clean_check[0] = (^r_s1_data[23:16])
                         ^ r_s1_data[0] ^ r_s1_data[4] ^ r_s1_data[8] ^ r_s1_data[12];
        w_clean_check[1] = (^r_s1_data[31:24])
                         ^ r_s1_data[1] ^ r_s1_data[5] ^ r_s1_data[9] ^ r_s1_data[13];
        w_clean_check[2] = (^r_s1_data[19:16]) ^ (^r_s1_data[27:24])
                         ^ r_s1_data[2] ^ r_s1_data[6] ^ r_s1_data[10] ^ r_s1_data[14];
        w_clean_check[3] = (^r_s1_data[23:20]) ^ (^r_s1_data[31:28])
                         ^ r_s1_data[3] ^ r_s1_data[7] ^ r_s1_data[11] ^ r_s1_data[15];
        w_clean_check[4] = (^r_s1_data[7:0])
                         ^ r_s1_data[16] ^ r_s1_data[20] ^ r_s1_data[24] ^ r_s1_data[28];
        w_clean_check[5] = (^r_s1_data[15:8])
                         ^ r_s1_data[17] ^ r_s1_data[21] ^ r_s1_data[25] ^ r_s1_data[29];
        w_clean_check[6] = (^r_s1_data[3:0]) ^ (^r_s1_data[11:8])
                         ^ r_s1_data[18] ^ r_s1_data[22] ^ r_s1_data[26] ^ r_s1_data[30];
        w_clean_check[7] = (^r_s1_data[7:4]) ^ (^r_s1_data[15:12])
                         ^ r_s1_data[19] ^ r_s1_data[23] ^ r_s1_data[27] ^ r_s1_data[31];
    end

    // Flip masks: positions 0-31 hit data, 32-39 hit check bits, 40-63 nothing.
    always_comb begin
        w_flip_data  = '0;
        w_flip_check = '0;
        if (r_s1_inj) begin
            if (!r_s1_pos[5]) begin
                w_flip_data = 32'h1 << r_s1_pos[4:0];
            end else if (r_s1_pos[5:3] == 3'b100) begin
                w_flip_check = 8'h1 << r_s1_pos[2:0];
            end
        end
    end

    // Arm/disarm the one-shot injector and remember the latest position.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inj_armed <= 1'b0;
            r_inj_pos   <= '0;
        end else begin
            if (inj_req) begin
                r_inj_pos <= inj_pos;
            end
            if (w_inj_take) begin
                r_inj_armed <= 1'b0;
            end else if (inj_req && (INJ_EN != 0)) begin
                r_inj_armed <= 1'b1;
            end
        end
    end

    // Stage 1: capture an accepted word; empty when it moves on with no refill.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_inj   <= 1'b0;
            r_s1_pos   <= '0;
        end else begin
            if (w_in_fire) begin
                r_s1_valid <= 1'b1;
                r_s1_data  <= in_data;
                r_s1_inj   <= w_inj_take;
                r_s1_pos   <= w_inj_take ? w_inj_sel_pos : 6'd0;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    // Stage 2: encode, apply flip, and hold the result until it is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_check <= '0;
            r_s2_inj   <= 1'b0;
        end else begin
            if (w_s1_adv) begin
                r_s2_valid <= 1'b1;
                r_s2_data  <= r_s1_data ^ w_flip_data;
                r_s2_check <= w_clean_check ^ w_flip_check;
                r_s2_inj   <= r_s1_inj;
            end else if (w_out_fire) begin
                r_s2_valid <= 1'b0;
                r_s2_inj   <= 1'b0;
            end
        end
    end

    // Count completed output handshakes, wrapping naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word_cnt <= '0;
        end else if (w_out_fire) begin
            r_word_cnt <= r_word_cnt + 1'b1;
        end
    end

    // Output drive.
    always_comb begin
        out_valid = r_s2_valid;
        out_en    = r_s2_valid;
        out_data  = r_s2_data;
        out_check = r_s2_check;
        word_cnt  = r_word_cnt;
        inj_done  = w_out_fire && r_s2_inj;
    end

endmodule
